// File: rtl/maxpool_layer.sv
// 2x2 stride-2 signed max pooling over a raster-ordered multi-channel frame.
// Horizontal pairs merge through a hold register; vertical pairs through a half-width line buffer.
module maxpool_layer #(
    parameter int POOL_DATA_WIDTH = 45,
    parameter int POOL_NUM_CH     = 8,
    parameter int POOL_X          = 24,
    parameter int POOL_Y          = 24
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pool_enable,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [POOL_NUM_CH*POOL_DATA_WIDTH-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [POOL_NUM_CH*POOL_DATA_WIDTH-1:0] out_data,
    output logic                                   out_last,
    output logic                                   pool_done
);

    // state | meaning
    // IDLE  | waiting for pool_enable; counters held at zero
    // RUN   | accepting pixels of the current frame
    // DRAIN | whole frame accepted, final pooled pixel waiting for transfer
    // DONE  | one-cycle frame-complete pulse

    localparam int W  = POOL_DATA_WIDTH;
    localparam int DW = POOL_NUM_CH * POOL_DATA_WIDTH;
    localparam int RW = $clog2(POOL_X);
    localparam int CW = $clog2(POOL_Y);
    localparam int HY = POOL_Y / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [DW-1:0]   hold;
    logic [DW-1:0]   line_buf [HY];
    logic [DW-1:0]   hmax;
    logic [DW-1:0]   vmax;
    logic [CW-2:0]   lb_idx;
    logic            accept;
    logic            last_col;
    logic            last_px;
    logic            out_xfer;

    function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col == CW'(POOL_Y - 1));
    assign last_px  = last_col && (row == RW'(POOL_X - 1));
    assign lb_idx   = col[CW-1:1];
    assign out_xfer = out_valid && out_ready;
    assign pool_done = (state == DONE);

    always_comb begin
        hmax = '0;
        vmax = '0;
        for (int k = 0; k < POOL_NUM_CH; k++) begin
            hmax[k*W +: W] = smax(hold[k*W +: W], in_data[k*W +: W]);
            vmax[k*W +: W] = smax(line_buf[lb_idx][k*W +: W], hmax[k*W +: W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pool_enable) state_nxt = RUN;
            RUN:     if (accept && last_px) state_nxt = DRAIN;
            DRAIN:   if (out_xfer && out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters sit at zero in IDLE, so every frame starts clean at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            hold <= '0;
        end else if (state == IDLE) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                hold <= in_data;
            end
            if (last_col) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Entries are always written on an even row before the odd row reads them.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            line_buf[lb_idx] <= hmax;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept && col[0] && row[0]) begin
            out_valid <= 1'b1;
            out_data  <= vmax;
            out_last  <= last_px;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
